// File: rtl/ysyx_23060136_wbu_pkg.sv
// Write-back unit package: FSM states, mem_fmt one-hot layout, stored payload.
`include "ysyx_23060136_defines.sv"

package ysyx_23060136_wbu_pkg;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        WAIT_LOAD = 2'd1,
        WRITE     = 2'd2
    } wbu_state_t;

    // mem_fmt bit positions: {word_u,half_u,byte_u,dword,word,half,byte}
    localparam int unsigned FMT_W      = 7;
    localparam int unsigned FMT_BYTE   = 0;
    localparam int unsigned FMT_HALF   = 1;
    localparam int unsigned FMT_WORD   = 2;
    localparam int unsigned FMT_DWORD  = 3;
    localparam int unsigned FMT_BYTE_U = 4;
    localparam int unsigned FMT_HALF_U = 5;
    localparam int unsigned FMT_WORD_U = 6;

    localparam logic [FMT_W-1:0] FMT_BYTE_OH   = 7'(1) << FMT_BYTE;
    localparam logic [FMT_W-1:0] FMT_HALF_OH   = 7'(1) << FMT_HALF;
    localparam logic [FMT_W-1:0] FMT_WORD_OH   = 7'(1) << FMT_WORD;
    localparam logic [FMT_W-1:0] FMT_DWORD_OH  = 7'(1) << FMT_DWORD;
    localparam logic [FMT_W-1:0] FMT_BYTE_U_OH = 7'(1) << FMT_BYTE_U;
    localparam logic [FMT_W-1:0] FMT_HALF_U_OH = 7'(1) << FMT_HALF_U;
    localparam logic [FMT_W-1:0] FMT_WORD_U_OH = 7'(1) << FMT_WORD_U;

    // Everything the stage must remember about one retiring instruction
    typedef struct packed {
        logic [`ysyx_23060136_BITS_W-1:0] pc;
        logic                             commit;
        logic [`ysyx_23060136_GPR_W-1:0]  rd;
        logic                             write_gpr;
        logic                             mem_to_reg;
        logic [FMT_W-1:0]                 mem_fmt;
        logic [`ysyx_23060136_BITS_W-1:0] alu_res;
        logic [`ysyx_23060136_BITS_W-1:0] csr_wdata;
        logic [`ysyx_23060136_BITS_W-1:0] rdata;
        logic [`ysyx_23060136_CSR_W-1:0]  csr_rd_1;
        logic [`ysyx_23060136_CSR_W-1:0]  csr_rd_2;
        logic                             write_csr_1;
        logic                             write_csr_2;
        logic                             ecall;
        logic                             halt;
    } wbu_payload_t;

endpackage

// File: rtl/ysyx_23060136_defines.sv
// Shared width macros and architectural constants for the ysyx_23060136 core.
`ifndef YSYX_23060136_DEFINES_SV
`define YSYX_23060136_DEFINES_SV

`define ysyx_23060136_BITS_W 64
`define ysyx_23060136_GPR_W 5
`define ysyx_23060136_INST_W 32
`define ysyx_23060136_CSR_W 12

// mcause value written on an environment call from M-mode
`define ysyx_23060136_MCAUSE_ECALL 64'd11

`endif

// File: rtl/ysyx_23060136_wbu_load_ext.sv
// Load-result extension: byte/half/word sign- or zero-extended, dword passed
// through; any mem_fmt that is not exactly one-hot yields zero.
`include "ysyx_23060136_defines.sv"

module ysyx_23060136_wbu_load_ext
    import ysyx_23060136_wbu_pkg::*;
(
    input  logic [`ysyx_23060136_BITS_W-1:0] rdata,
    input  logic [FMT_W-1:0]                 mem_fmt,
    output logic [`ysyx_23060136_BITS_W-1:0] ext
);

    // Select extension by the one-hot format; default covers zero/multi-hot
    always_comb begin
        ext = '0;
        case (mem_fmt)
            FMT_BYTE_OH:   ext = {{56{rdata[7]}},  rdata[7:0]};
            FMT_HALF_OH:   ext = {{48{rdata[15]}}, rdata[15:0]};
            FMT_WORD_OH:   ext = {{32{rdata[31]}}, rdata[31:0]};
            FMT_DWORD_OH:  ext = rdata;
            FMT_BYTE_U_OH: ext = {56'd0, rdata[7:0]};
            FMT_HALF_U_OH: ext = {48'd0, rdata[15:0]};
            FMT_WORD_U_OH: ext = {32'd0, rdata[31:0]};
            default:       ext = '0;
        endcase
    end

endmodule

// File: rtl/ysyx_23060136_wbu_top.sv
// Write-back unit: holds one retiring instruction, waits for load data when
// needed, then drives the GPR and CSR write ports for exactly one cycle.
// Optional: define YSYX_23060136_WBU_RETIRE_CNT_EN to add a 64-bit retire counter.
`include "ysyx_23060136_defines.sv"

module ysyx_23060136_wbu_top
    import ysyx_23060136_wbu_pkg::*;
(
    input  logic                             clk,
    input  logic                             rst,

    input  logic                             WB_i_valid,
    output logic                             WB_o_ready,

    input  logic [`ysyx_23060136_BITS_W-1:0] WB_i_pc,
    input  logic [`ysyx_23060136_INST_W-1:0] WB_i_inst,
    input  logic                             WB_i_commit,

    input  logic [`ysyx_23060136_GPR_W-1:0]  WB_i_rd,
    input  logic                             WB_i_write_gpr,
    input  logic                             WB_i_mem_to_reg,
    input  logic [6:0]                       WB_i_mem_fmt,

    input  logic [`ysyx_23060136_BITS_W-1:0] WB_i_alu_res,
    input  logic [`ysyx_23060136_BITS_W-1:0] WB_i_csr_wdata,

    input  logic [`ysyx_23060136_BITS_W-1:0] WB_i_rdata,
    input  logic                             WB_i_rdata_valid,

    input  logic [`ysyx_23060136_CSR_W-1:0]  WB_i_csr_rd_1,
    input  logic [`ysyx_23060136_CSR_W-1:0]  WB_i_csr_rd_2,
    input  logic                             WB_i_write_csr_1,
    input  logic                             WB_i_write_csr_2,
    input  logic                             WB_i_ecall,
    input  logic                             WB_i_halt,

    output logic [`ysyx_23060136_GPR_W-1:0]  WB_o_rd,
    output logic                             WB_o_RegWr,
    output logic [`ysyx_23060136_BITS_W-1:0] WB_o_rf_busW,

    output logic [`ysyx_23060136_CSR_W-1:0]  WB_o_csr_rd_1,
    output logic [`ysyx_23060136_CSR_W-1:0]  WB_o_csr_rd_2,
    output logic                             WB_o_CSRWr_1,
    output logic                             WB_o_CSRWr_2,
    output logic [`ysyx_23060136_BITS_W-1:0] WB_o_csr_busW_1,
    output logic [`ysyx_23060136_BITS_W-1:0] WB_o_csr_busW_2,

    output logic [`ysyx_23060136_BITS_W-1:0] WB_o_pc,
    output logic                             WB_o_commit,
`ifdef YSYX_23060136_WBU_RETIRE_CNT_EN
    output logic [63:0]                      WB_o_retire_cnt,
`endif
    output logic                             WB_o_system_halt
);

    wbu_state_t   state_q, state_d;
    wbu_payload_t pay_q, entry;
    logic         halt_q;
    logic         accept;
    logic         in_write;
    logic [`ysyx_23060136_BITS_W-1:0] load_ext;

    // The instruction word is carried only for tracing upstream; not needed here.
    logic inst_unused;
    assign inst_unused = ^WB_i_inst;

    assign in_write = (state_q == WRITE);
    assign accept   = WB_i_valid & WB_o_ready;

    // Halt is visible in the ebreak's own WRITE cycle so nothing slips in behind it.
    assign WB_o_system_halt = halt_q | (in_write & pay_q.halt);

    // Pack the incoming instruction; load data arrives later
    always_comb begin
        entry             = '0;
        entry.pc          = WB_i_pc;
        entry.commit      = WB_i_commit;
        entry.rd          = WB_i_rd;
        entry.write_gpr   = WB_i_write_gpr;
        entry.mem_to_reg  = WB_i_mem_to_reg;
        entry.mem_fmt     = WB_i_mem_fmt;
        entry.alu_res     = WB_i_alu_res;
        entry.csr_wdata   = WB_i_csr_wdata;
        entry.csr_rd_1    = WB_i_csr_rd_1;
        entry.csr_rd_2    = WB_i_csr_rd_2;
        entry.write_csr_1 = WB_i_write_csr_1;
        entry.write_csr_2 = WB_i_write_csr_2;
        entry.ecall       = WB_i_ecall;
        entry.halt        = WB_i_halt;
    end

    // State, payload and sticky halt registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            pay_q   <= '0;
            halt_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                pay_q <= entry;
            end else if ((state_q == WAIT_LOAD) && WB_i_rdata_valid) begin
                pay_q.rdata <= WB_i_rdata;
            end
            if (in_write && pay_q.halt) begin
                halt_q <= 1'b1;
            end
        end
    end

    ysyx_23060136_wbu_load_ext u_load_ext (
        .rdata   (pay_q.rdata),
        .mem_fmt (pay_q.mem_fmt),
        .ext     (load_ext)
    );

    // Next-state and write-port outputs; every port is quiet outside WRITE
    always_comb begin
        state_d         = state_q;
        WB_o_ready      = 1'b0;
        WB_o_rd         = '0;
        WB_o_RegWr      = 1'b0;
        WB_o_rf_busW    = '0;
        WB_o_csr_rd_1   = '0;
        WB_o_csr_rd_2   = '0;
        WB_o_CSRWr_1    = 1'b0;
        WB_o_CSRWr_2    = 1'b0;
        WB_o_csr_busW_1 = '0;
        WB_o_csr_busW_2 = '0;
        WB_o_pc         = '0;
        WB_o_commit     = 1'b0;

        WB_o_ready = (state_q != WAIT_LOAD) && !WB_o_system_halt;

        case (state_q)
            IDLE, WRITE: begin
                if (accept) begin
                    state_d = WB_i_mem_to_reg ? WAIT_LOAD : WRITE;
                end else begin
                    state_d = IDLE;
                end
            end
            WAIT_LOAD: begin
                if (WB_i_rdata_valid) begin
                    state_d = WRITE;
                end
            end
            default: state_d = IDLE;
        endcase

        if (in_write) begin
            WB_o_rd       = pay_q.rd;
            WB_o_RegWr    = pay_q.write_gpr && (pay_q.rd != '0);
            WB_o_rf_busW  = pay_q.mem_to_reg ? load_ext : pay_q.alu_res;
            WB_o_csr_rd_1 = pay_q.csr_rd_1;
            WB_o_csr_rd_2 = pay_q.csr_rd_2;
            WB_o_pc       = pay_q.pc;
            WB_o_commit   = pay_q.commit;
            if (pay_q.ecall) begin
                WB_o_CSRWr_1    = 1'b1;
                WB_o_CSRWr_2    = 1'b1;
                WB_o_csr_busW_1 = pay_q.pc;
                WB_o_csr_busW_2 = `ysyx_23060136_MCAUSE_ECALL;
            end else begin
                WB_o_CSRWr_1    = pay_q.write_csr_1;
                WB_o_CSRWr_2    = pay_q.write_csr_2;
                WB_o_csr_busW_1 = pay_q.csr_wdata;
                WB_o_csr_busW_2 = '0;
            end
        end
    end

`ifdef YSYX_23060136_WBU_RETIRE_CNT_EN
    // Count retired instructions
    always_ff @(posedge clk) begin
        if (rst) begin
            WB_o_retire_cnt <= '0;
        end else if (WB_o_commit) begin
            WB_o_retire_cnt <= WB_o_retire_cnt + 64'd1;
        end
    end
`endif

endmodule
